lake_stream_harness: RTL and testbench

- Synthesizable stimulus/capture engine for on-FPGA and emulation bring-up of lakespec-style static-schedule memories.
- Drives NUM_IN data streams into the DUT input ports as affine ramps and records NUM_OUT DUT output streams into per-channel capture RAMs.
- Runs a configured start delay, then a fixed number of cycles. Exposes done, cycle count and a registered capture readback port.

---
 rtl/lake_stream_harness_pkg.sv | 19 +
 rtl/lake_stream_harness_ag.sv | 41 ++++
 rtl/lake_stream_harness.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_lake_stream_harness.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lake_stream_harness_pkg.sv
// Shared types and width helpers for the lake_stream_harness stimulus/capture engine.
package lake_stream_harness_pkg;

   typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_e;

   typedef enum logic {MODE_RAMP, MODE_HOLD} mode_e;

   localparam int unsigned DEF_NUM_OUT   = 2;
   localparam int unsigned DEF_CAP_DEPTH = 1024;

   // Index width for n items, never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_SEL_W  = idx_w(DEF_NUM_OUT);
   localparam int unsigned DEF_ADDR_W = idx_w(DEF_CAP_DEPTH);

endpackage

// File: rtl/lake_stream_harness_ag.sv
// Accumulator-based affine generator: value = base + stride * steps, no multiplier.
module lake_stream_harness_ag #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] stride,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;

   // Next accumulator value: clear beats load beats step.
   always_comb begin
      acc_d = acc_q;
      if (clear) begin
         acc_d = '0;
      end else if (load) begin
         acc_d = base;
      end else if (step) begin
         acc_d = acc_q + stride;
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign value = acc_q;

endmodule

// File: rtl/lake_stream_harness.sv
// Stimulus/capture engine: drives affine ramps, captures DUT outputs into per-channel RAMs.
// Optional on-line checker enabled by defining LAKE_STREAM_HARNESS_CHECK_EN.
module lake_stream_harness
   import lake_stream_harness_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = 16,
   parameter  int unsigned NUM_IN     = 2,
   parameter  int unsigned NUM_OUT    = 2,
   parameter  int unsigned CAP_DEPTH  = 1024,
   parameter  int unsigned CYC_W      = 32,
   localparam int unsigned SEL_W      = idx_w(NUM_OUT),
   localparam int unsigned ADDR_W     = idx_w(CAP_DEPTH)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           start,
   input  logic [CYC_W-1:0]               cfg_num_cycles,
   input  logic [CYC_W-1:0]               cfg_start_delay,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   cfg_base,
   input  logic [NUM_IN*DATA_WIDTH-1:0]   cfg_stride,
   input  logic [NUM_IN-1:0]              cfg_mode,
   output logic [NUM_IN*DATA_WIDTH-1:0]   stim_data,
   output logic                           stim_valid,
   input  logic [NUM_OUT*DATA_WIDTH-1:0]  cap_data,
`ifdef LAKE_STREAM_HARNESS_CHECK_EN
   input  logic [NUM_OUT*DATA_WIDTH-1:0]  cfg_exp_base,
   input  logic [NUM_OUT*DATA_WIDTH-1:0]  cfg_exp_stride,
   input  logic [CYC_W-1:0]               cfg_exp_lat,
   output logic [31:0]                    mismatch_count,
   output logic [CYC_W-1:0]               first_mismatch_idx,
   output logic [SEL_W-1:0]               first_mismatch_ch,
`endif
   input  logic [SEL_W-1:0]               cap_rd_sel,
   input  logic [ADDR_W-1:0]              cap_rd_addr,
   output logic [DATA_WIDTH-1:0]          cap_rd_data,
   output logic                           busy,
   output logic                           done,
   output logic                           overflow,
   output logic [63:0]                    cycle_count
);

   localparam logic [CYC_W-1:0] ONE     = CYC_W'(1);
   localparam logic [CYC_W-1:0] CAP_LIM = CYC_W'(CAP_DEPTH);

   state_e                      state_q, state_d;
   logic [CYC_W-1:0]            dly_q, dly_d;
   logic [CYC_W-1:0]            num_q, num_d;
   logic [CYC_W-1:0]            idx_q, idx_d;
   logic [NUM_IN*DATA_WIDTH-1:0] base_q, base_d;
   logic [NUM_IN*DATA_WIDTH-1:0] stride_q, stride_d;
   logic [NUM_IN-1:0]           mode_q, mode_d;
   logic [63:0]                 cyc_q, cyc_d;
   logic                        ovf_q, ovf_d;
   logic                        valid_q, valid_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic [DATA_WIDTH-1:0]       rd_q, rd_d;

   logic                        start_take;
   logic                        ag_clear;
   logic                        ag_load;
   logic                        run_step;
   logic                        wr_en;
   logic [ADDR_W-1:0]           wr_addr;
   logic [NUM_IN*DATA_WIDTH-1:0] ag_base;
   logic [NUM_OUT*DATA_WIDTH-1:0] rd_flat;

   assign start_take = start && !flush && ((state_q == IDLE) || (state_q == DONE));
   // The generator load happens either straight from IDLE/DONE (cfg not yet latched) or from DELAY.
   assign ag_base    = (state_q == DELAY) ? base_q : cfg_base;
   assign wr_addr    = idx_q[ADDR_W-1:0];

   // Run-state next-value logic; flush overrides everything including start.
   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      num_d    = num_q;
      idx_d    = idx_q;
      base_d   = base_q;
      stride_d = stride_q;
      mode_d   = mode_q;
      cyc_d    = cyc_q;
      ovf_d    = ovf_q;
      ag_clear = 1'b0;
      ag_load  = 1'b0;
      run_step = 1'b0;
      wr_en    = 1'b0;
      if (flush) begin
         state_d  = IDLE;
         ag_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (start_take) begin
                  base_d   = cfg_base;
                  stride_d = cfg_stride;
                  mode_d   = cfg_mode;
                  num_d    = cfg_num_cycles;
                  dly_d    = cfg_start_delay;
                  idx_d    = '0;
                  cyc_d    = '0;
                  ovf_d    = 1'b0;
                  if (cfg_start_delay != '0) begin
                     state_d = DELAY;
                  end else if (cfg_num_cycles != '0) begin
                     state_d = RUN;
                     ag_load = 1'b1;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            DELAY: begin
               if (dly_q <= ONE) begin
                  if (num_q != '0) begin
                     state_d = RUN;
                     ag_load = 1'b1;
                  end else begin
                     state_d = DONE;
                  end
               end else begin
                  dly_d = dly_q - ONE;
               end
            end
            RUN: begin
               cyc_d = cyc_q + 64'd1;
               if (idx_q < CAP_LIM) begin
                  wr_en = 1'b1;
               end else begin
                  ovf_d = 1'b1;
               end
               if (idx_q == num_q - ONE) begin
                  state_d = DONE;
               end else begin
                  idx_d    = idx_q + ONE;
                  run_step = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      valid_d = (state_d == RUN);
      busy_d  = (state_d == DELAY) || (state_d == RUN);
      done_d  = (state_d == DONE);
   end

   // Run-state and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         dly_q    <= '0;
         num_q    <= '0;
         idx_q    <= '0;
         base_q   <= '0;
         stride_q <= '0;
         mode_q   <= '0;
         cyc_q    <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         num_q    <= num_d;
         idx_q    <= idx_d;
         base_q   <= base_d;
         stride_q <= stride_d;
         mode_q   <= mode_d;
         cyc_q    <= cyc_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   for (genvar c = 0; c < NUM_IN; c++) begin : g_stim
      lake_stream_harness_ag #(.WIDTH(DATA_WIDTH)) u_ag (
         .clk    (clk),
         .rst    (rst),
         .clear  (ag_clear),
         .load   (ag_load),
         .step   (run_step && (mode_e'(mode_q[c]) == MODE_RAMP)),
         .base   (ag_base[c*DATA_WIDTH +: DATA_WIDTH]),
         .stride (stride_q[c*DATA_WIDTH +: DATA_WIDTH]),
         .value  (stim_data[c*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_cap
      logic [DATA_WIDTH-1:0] mem [CAP_DEPTH];

      // Capture write; contents are deliberately not reset.
      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[wr_addr] <= cap_data[o*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      assign rd_flat[o*DATA_WIDTH +: DATA_WIDTH] = mem[cap_rd_addr];
   end

   // Readback channel select; out-of-range selects read as zero.
   always_comb begin
      rd_d = '0;
      for (int unsigned o = 0; o < NUM_OUT; o++) begin
         if (32'(cap_rd_sel) == o) begin
            rd_d = rd_flat[o*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Readback register; sampling before the same-edge write returns the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
      end else begin
         rd_q <= rd_d;
      end
   end

`ifdef LAKE_STREAM_HARNESS_CHECK_EN
   logic [NUM_OUT*DATA_WIDTH-1:0] exp_stride_q, exp_stride_d;
   logic [NUM_OUT*DATA_WIDTH-1:0] exp_val;
   logic [CYC_W-1:0]              exp_lat_q, exp_lat_d;
   logic [31:0]                   mm_cnt_q, mm_cnt_d;
   logic [CYC_W-1:0]              mm_idx_q, mm_idx_d;
   logic [SEL_W-1:0]              mm_ch_q, mm_ch_d;
   logic [NUM_OUT-1:0]            mm_vec;
   logic                          chk_active;
   logic                          first_free;

   assign chk_active = (state_q == RUN) && !flush && (idx_q >= exp_lat_q);

   for (genvar o = 0; o < NUM_OUT; o++) begin : g_chk
      lake_stream_harness_ag #(.WIDTH(DATA_WIDTH)) u_exp (
         .clk    (clk),
         .rst    (rst),
         .clear  (1'b0),
         .load   (start_take),
         .step   (chk_active),
         .base   (cfg_exp_base[o*DATA_WIDTH +: DATA_WIDTH]),
         .stride (exp_stride_q[o*DATA_WIDTH +: DATA_WIDTH]),
         .value  (exp_val[o*DATA_WIDTH +: DATA_WIDTH])
      );
      assign mm_vec[o] = cap_data[o*DATA_WIDTH +: DATA_WIDTH] != exp_val[o*DATA_WIDTH +: DATA_WIDTH];
   end

   // Mismatch accounting: saturating count, first failing index and lowest failing channel.
   always_comb begin
      exp_stride_d = exp_stride_q;
      exp_lat_d    = exp_lat_q;
      mm_cnt_d     = mm_cnt_q;
      mm_idx_d     = mm_idx_q;
      mm_ch_d      = mm_ch_q;
      first_free   = (mm_cnt_q == '0);
      if (start_take) begin
         exp_stride_d = cfg_exp_stride;
         exp_lat_d    = cfg_exp_lat;
         mm_cnt_d     = '0;
         mm_idx_d     = '0;
         mm_ch_d      = '0;
      end else if (chk_active) begin
         for (int unsigned o = 0; o < NUM_OUT; o++) begin
            if (mm_vec[o]) begin
               if (mm_cnt_d != '1) begin
                  mm_cnt_d = mm_cnt_d + 32'd1;
               end
               if (first_free) begin
                  first_free = 1'b0;
                  mm_idx_d   = idx_q;
                  mm_ch_d    = SEL_W'(o);
               end
            end
         end
      end
   end

   // Checker registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_stride_q <= '0;
         exp_lat_q    <= '0;
         mm_cnt_q     <= '0;
         mm_idx_q     <= '0;
         mm_ch_q      <= '0;
      end else begin
         exp_stride_q <= exp_stride_d;
         exp_lat_q    <= exp_lat_d;
         mm_cnt_q     <= mm_cnt_d;
         mm_idx_q     <= mm_idx_d;
         mm_ch_q      <= mm_ch_d;
      end
   end

   assign mismatch_count     = mm_cnt_q;
   assign first_mismatch_idx = mm_idx_q;
   assign first_mismatch_ch  = mm_ch_q;
`endif

   assign stim_valid  = valid_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign overflow    = ovf_q;
   assign cycle_count = cyc_q;
   assign cap_rd_data = rd_q;

endmodule

// File: tb/tb_lake_stream_harness.sv
// Directed bench for lake_stream_harness; stim_data loops back to cap_data through one register.
module tb_lake_stream_harness;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        start = 1'b0;
   logic [31:0] cfg_num_cycles = '0;
   logic [31:0] cfg_start_delay = '0;
   logic [31:0] cfg_base = '0;
   logic [31:0] cfg_stride = '0;
   logic [1:0]  cfg_mode = '0;
   logic [31:0] stim_data;
   logic        stim_valid;
   logic [31:0] cap_data;
   logic [0:0]  cap_rd_sel = '0;
   logic [9:0]  cap_rd_addr = '0;
   logic [15:0] cap_rd_data;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [63:0] cycle_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cap_data <= stim_data;

   lake_stream_harness #(
      .DATA_WIDTH (16),
      .NUM_IN     (2),
      .NUM_OUT    (2),
      .CAP_DEPTH  (1024),
      .CYC_W      (32)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .start           (start),
      .cfg_num_cycles  (cfg_num_cycles),
      .cfg_start_delay (cfg_start_delay),
      .cfg_base        (cfg_base),
      .cfg_stride      (cfg_stride),
      .cfg_mode        (cfg_mode),
      .stim_data       (stim_data),
      .stim_valid      (stim_valid),
      .cap_data        (cap_data),
      .cap_rd_sel      (cap_rd_sel),
      .cap_rd_addr     (cap_rd_addr),
      .cap_rd_data     (cap_rd_data),
      .busy            (busy),
      .done            (done),
      .overflow        (overflow),
      .cycle_count     (cycle_count)
   );

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step_clk();
      start = 1'b0;
   endtask

   task automatic read_cap(input logic sel, input logic [9:0] addr, output logic [15:0] data);
      cap_rd_sel  = sel;
      cap_rd_addr = addr;
      step_clk();
      data = cap_rd_data;
   endtask

   // Waits for done within a cycle budget; returns 1 if it arrived.
   task automatic wait_done(input int budget, output bit ok);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         step_clk();
         n++;
      end
      ok = (done === 1'b1);
   endtask

   task automatic test_reset();
      step_clk();
      step_clk();
      checks++; if (stim_data !== 32'h0) begin errors++; $display("FAIL reset_stim_data got %h want 0", stim_data); end
      checks++; if (stim_valid !== 1'b0) begin errors++; $display("FAIL reset_stim_valid got %b want 0", stim_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
      checks++; if (cycle_count !== 64'd0) begin errors++; $display("FAIL reset_cycle_count got %0d want 0", cycle_count); end
      checks++; if (cap_rd_data !== 16'h0) begin errors++; $display("FAIL reset_cap_rd_data got %h want 0", cap_rd_data); end
      rst = 1'b0;
      step_clk();
      step_clk();
   endtask

   task automatic test_ramp_capture();
      bit ok;
      logic [15:0] d;
      logic [9:0]  addrs [5] = '{10'd0, 10'd1, 10'd2, 10'd500, 10'd999};
      logic [15:0] exps  [5] = '{16'd0, 16'd0, 16'd2, 16'd998, 16'd1996};
      cfg_num_cycles  = 32'd1000;
      cfg_start_delay = 32'd0;
      cfg_base        = {16'h0100, 16'h0000};
      cfg_stride      = {16'h0001, 16'h0002};
      cfg_mode        = 2'b00;
      pulse_start();
      wait_done(1100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ramp_done_timeout got done=%b want 1", done); end
      checks++; if (cycle_count !== 64'd1000) begin errors++; $display("FAIL ramp_cycle_count got %0d want 1000", cycle_count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ramp_overflow got %b want 0", overflow); end
      checks++; if (busy !== 1'b0 || stim_valid !== 1'b0) begin errors++; $display("FAIL ramp_idle_flags got busy=%b valid=%b want 0 0", busy, stim_valid); end
      checks++; if (stim_data[15:0] !== 16'd1998) begin errors++; $display("FAIL ramp_hold_last got %0d want 1998", stim_data[15:0]); end
      for (int i = 0; i < 5; i++) begin
         read_cap(1'b0, addrs[i], d);
         checks++; if (d !== exps[i]) begin errors++; $display("FAIL ramp_ram0[%0d] got %0d want %0d", addrs[i], d, exps[i]); end
      end
      read_cap(1'b1, 10'd3, d);
      checks++; if (d !== 16'h0102) begin errors++; $display("FAIL ramp_ram1[3] got %h want 0102", d); end
   endtask

   task automatic test_two_channel_delay();
      int cyc;
      cfg_num_cycles  = 32'd8;
      cfg_start_delay = 32'd4;
      cfg_base        = {16'hABCD, 16'd5};
      cfg_stride      = {16'h0007, 16'd3};
      cfg_mode        = 2'b10;
      pulse_start();
      cyc = 1;
      while (stim_valid !== 1'b1 && cyc < 20) begin
         step_clk();
         cyc++;
      end
      checks++; if (cyc != 5) begin errors++; $display("FAIL delay_valid_rise got %0d cycles want 5", cyc); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (stim_data[15:0] !== 16'(5 + 3*i)) begin errors++; $display("FAIL delay_ch0[%0d] got %0d want %0d", i, stim_data[15:0], 5 + 3*i); end
         checks++; if (stim_data[31:16] !== 16'hABCD) begin errors++; $display("FAIL delay_ch1[%0d] got %h want abcd", i, stim_data[31:16]); end
         checks++; if (stim_valid !== 1'b1) begin errors++; $display("FAIL delay_valid[%0d] got %b want 1", i, stim_valid); end
         step_clk();
      end
      checks++; if (stim_valid !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL delay_end got valid=%b done=%b want 0 1", stim_valid, done); end
      checks++; if (stim_data[15:0] !== 16'd26) begin errors++; $display("FAIL delay_hold got %0d want 26", stim_data[15:0]); end
      checks++; if (cycle_count !== 64'd8) begin errors++; $display("FAIL delay_cycle_count got %0d want 8", cycle_count); end
   endtask

   task automatic test_wrap();
      int cyc;
      logic [15:0] exps [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      cfg_num_cycles  = 32'd4;
      cfg_start_delay = 32'd0;
      cfg_base        = {16'h5555, 16'hFFFE};
      cfg_stride      = {16'h0000, 16'h0001};
      cfg_mode        = 2'b10;
      pulse_start();
      cyc = 1;
      while (stim_valid !== 1'b1 && cyc < 20) begin
         step_clk();
         cyc++;
      end
      checks++; if (cyc != 1) begin errors++; $display("FAIL wrap_valid_rise got %0d cycles want 1", cyc); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (stim_data[15:0] !== exps[i]) begin errors++; $display("FAIL wrap_ch0[%0d] got %h want %h", i, stim_data[15:0], exps[i]); end
         step_clk();
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b want 1", done); end
   endtask

   task automatic test_overflow();
      bit ok;
      logic [15:0] d;
      logic        sels  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0]  addrs [6] = '{10'd0, 10'd1, 10'd5, 10'd1023, 10'd0, 10'd1023};
      logic [15:0] exps  [6] = '{16'h0001, 16'd0, 16'd8, 16'd2044, 16'h5555, 16'h1234};
      cfg_num_cycles  = 32'd1030;
      cfg_start_delay = 32'd0;
      cfg_base        = {16'h1234, 16'h0000};
      cfg_stride      = {16'h0009, 16'h0002};
      cfg_mode        = 2'b10;
      pulse_start();
      wait_done(1200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_done_timeout got done=%b want 1", done); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
      checks++; if (cycle_count !== 64'd1030) begin errors++; $display("FAIL ovf_cycle_count got %0d want 1030", cycle_count); end
      for (int i = 0; i < 6; i++) begin
         read_cap(sels[i], addrs[i], d);
         checks++; if (d !== exps[i]) begin errors++; $display("FAIL ovf_ram%0d[%0d] got %h want %h", sels[i], addrs[i], d, exps[i]); end
      end
   endtask

   task automatic test_flush();
      bit ok;
      cfg_num_cycles  = 32'd100;
      cfg_start_delay = 32'd0;
      cfg_base        = {16'h0000, 16'h0000};
      cfg_stride      = {16'h0001, 16'h0001};
      cfg_mode        = 2'b00;
      pulse_start();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf_cleared got %b want 0", overflow); end
      for (int k = 0; k < 10; k++) step_clk();
      checks++; if (stim_data[15:0] !== 16'd10 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre got stim=%0d busy=%b want 10 1", stim_data[15:0], busy); end
      flush = 1'b1;
      step_clk();
      flush = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || stim_valid !== 1'b0) begin errors++; $display("FAIL flush_flags got busy=%b done=%b valid=%b want 0 0 0", busy, done, stim_valid); end
      checks++; if (stim_data !== 32'h0) begin errors++; $display("FAIL flush_stim got %h want 0", stim_data); end
      checks++; if (cycle_count !== 64'd10) begin errors++; $display("FAIL flush_cycle_count got %0d want 10", cycle_count); end
      flush = 1'b1;
      start = 1'b1;
      step_clk();
      flush = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0 || stim_valid !== 1'b0) begin errors++; $display("FAIL flush_over_start got busy=%b valid=%b want 0 0", busy, stim_valid); end
      pulse_start();
      wait_done(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL flush_rerun_timeout got done=%b want 1", done); end
      checks++; if (cycle_count !== 64'd100) begin errors++; $display("FAIL flush_rerun_count got %0d want 100", cycle_count); end
      checks++; if (stim_data[15:0] !== 16'd99) begin errors++; $display("FAIL flush_rerun_last got %0d want 99", stim_data[15:0]); end
   endtask

   task automatic test_zero_and_busy();
      bit ok;
      bit saw_valid = 1'b0;
      int n = 0;
      cfg_num_cycles  = 32'd0;
      cfg_start_delay = 32'd0;
      pulse_start();
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_direct got done=%b busy=%b want 1 0", done, busy); end
      checks++; if (cycle_count !== 64'd0) begin errors++; $display("FAIL zero_direct_count got %0d want 0", cycle_count); end
      cfg_start_delay = 32'd3;
      pulse_start();
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL zero_delay_busy got busy=%b done=%b want 1 0", busy, done); end
      cfg_num_cycles = 32'd50;
      pulse_start();
      while (done !== 1'b1 && n < 20) begin
         if (stim_valid === 1'b1) saw_valid = 1'b1;
         step_clk();
         n++;
      end
      ok = (done === 1'b1);
      checks++; if (!ok) begin errors++; $display("FAIL zero_delay_timeout got done=%b want 1", done); end
      checks++; if (saw_valid) begin errors++; $display("FAIL zero_no_run got stim_valid=1 want 0"); end
      checks++; if (cycle_count !== 64'd0) begin errors++; $display("FAIL zero_delay_count got %0d want 0", cycle_count); end
   endtask

   initial begin
      #1;
      test_reset();
      test_ramp_capture();
      test_two_channel_delay();
      test_wrap();
      test_overflow();
      test_flush();
      test_zero_and_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
